// File: rtl/code_display_pkg.sv
// code_display_pkg: states, segment patterns (bit 0 = segment a) and digit-select codes
// for the two-digit code display.
`default_nettype none

package code_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    SHOW = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  // Stored as {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/code_display_ctrl_seg7.sv
// seg7_digit: decimal digit 0..9 to seven active-high segments; any other input blanks.
`default_nettype none

module seg7_digit
  import code_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/code_display_ctrl.sv
// code_display_ctrl: captures a 4-bit code with a valid/ack handshake, holds it for a
// minimum time and shows it in decimal on a two-digit multiplexed seven-segment display.
`default_nettype none

module code_display_ctrl
  import code_display_pkg::*;
#(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       code_valid,
  input  logic       clear,
  output logic       code_ack,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       busy
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  value;
  logic [15:0] hold_cnt;
  logic [15:0] scan_cnt;
  logic        capture;
  logic        tens;
  logic [3:0]  units;
  logic [3:0]  digit_mux;
  logic [6:0]  digit_seg;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!clear && code_valid) state_next = LOAD;
      LOAD: state_next = HOLD;
      HOLD: begin
        if (clear)                       state_next = IDLE;
        else if (hold_cnt == HOLD_LAST)  state_next = SHOW;
      end
      SHOW: begin
        if (clear)           state_next = IDLE;
        else if (code_valid) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only IDLE and SHOW can move into LOAD, so this is exactly the capture condition.
  assign capture = (state_next == LOAD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      value    <= 4'd0;
      hold_cnt <= 16'd0;
      scan_cnt <= 16'd0;
      dig_sel  <= DIG_UNITS;
      code_ack <= 1'b0;
    end else begin
      state    <= state_next;
      code_ack <= capture;
      if (capture) value <= code;
      if (state == LOAD)      hold_cnt <= 16'd0;
      else if (state == HOLD) hold_cnt <= hold_cnt + 16'd1;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= 16'd0;
        dig_sel  <= (dig_sel == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
    end
  end

  assign tens      = (value >= 4'd10);
  assign units     = tens ? (value - 4'd10) : value;
  assign digit_mux = (dig_sel == DIG_TENS) ? {3'b000, tens} : units;

  seg7_digit u_seg7 (
    .digit (digit_mux),
    .seg   (digit_seg)
  );

  // A leading zero on the tens digit is suppressed rather than drawn as "0".
  assign seg  = ((state == IDLE) || ((dig_sel == DIG_TENS) && !tens)) ? SEG_BLANK : digit_seg;
  assign busy = (state == LOAD) || (state == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_code_display_ctrl.sv
// tb_code_display_ctrl: directed stimulus with a queue of expected acknowledged codes and a
// negedge monitor that checks handshake, digit scan and segment outputs.
`default_nettype none

module tb_code_display_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] code = 4'd0;
  logic       code_valid = 1'b0;
  logic       clear = 1'b0;
  logic       code_ack;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       busy;

  always #5 clk = ~clk;

  code_display_ctrl #(
    .SCAN_DIV    (4),
    .HOLD_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .clear      (clear),
    .code_ack   (code_ack),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Patterns written in a..g order, MSB = a, exactly as the segment table reads.
  logic [6:0] pat_abcdefg [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1110011};

  function automatic logic [6:0] to_seg(input logic [6:0] abcdefg);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = abcdefg[6-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit-scan reference: SCAN_DIV = 4 cycles per digit, starting on units.
  logic [1:0] m_sel = 2'b01;
  int         m_scan = 0;
  always @(posedge clk) begin
    if (!reset) begin
      m_scan <= 0;
      m_sel  <= 2'b01;
    end else if (m_scan == 3) begin
      m_scan <= 0;
      m_sel  <= ~m_sel;
    end else begin
      m_scan <= m_scan + 1;
    end
  end

  // Monitor / scoreboard.
  bit         chk_en = 1'b0;
  int         blank_evt = 0;
  int         seen_evt = 0;
  bit         m_blank = 1'b1;
  logic [3:0] m_val = 4'd0;
  logic       prev_ack = 1'b0;
  int         ack_cnt = 0;
  logic [6:0] es;

  always @(negedge clk) begin
    if (blank_evt != seen_evt) begin
      seen_evt = blank_evt;
      m_blank  = 1'b1;
    end
    if (code_ack === 1'b1) begin
      ack_cnt++;
      chk("ack_single_cycle", 16'(prev_ack), 16'd0);
      chk("ack_busy", 16'(busy), 16'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got code_ack=1 expected 0 at %0t", $time);
      end else begin
        m_val   = exp_q.pop_front();
        m_blank = 1'b0;
      end
    end
    prev_ack = code_ack;
    if (chk_en) begin
      if (m_blank)             es = 7'd0;
      else if (m_sel == 2'b10) es = (m_val >= 4'd10) ? to_seg(pat_abcdefg[1]) : 7'd0;
      else                     es = to_seg(pat_abcdefg[(m_val >= 4'd10) ? m_val - 4'd10 : m_val]);
      chk("dig_sel", 16'(dig_sel), 16'(m_sel));
      chk("seg", 16'(seg), 16'(es));
      if (m_blank) chk("busy_idle", 16'(busy), 16'd0);
    end
  end

  // All stimulus steps start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input int exp_lat);
    int  n;
    bit  got;
    exp_q.push_back(c);
    code       = c;
    code_valid = 1'b1;
    n   = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge clk);
      n++;
      if (code_ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no code_ack in %0d cycles expected latency %0d", n, exp_lat);
    end else begin
      chk("ack_latency", 16'(n), 16'(exp_lat));
    end
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  int base_acks;

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion expected finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_seg", 16'(seg), 16'd0);
    chk("reset_dig_sel", 16'(dig_sel), 16'h1);
    chk("reset_ack", 16'(code_ack), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    idle(1);
    chk_en = 1'b1;
    idle(10);

    send(4'd7, 2);
    idle(20);

    send(4'd13, 2);
    send(4'd2, 18);
    idle(20);

    send(4'd15, 2);
    idle(20);

    // Clear and a new code together in SHOW: clear wins.
    clear      = 1'b1;
    code_valid = 1'b1;
    code       = 4'd5;
    idle(1);
    clear      = 1'b0;
    code_valid = 1'b0;
    blank_evt++;
    idle(10);

    send(4'd9, 2);
    @(negedge clk);
    chk("hold_busy", 16'(busy), 16'd1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b0;
    blank_evt++;
    idle(2);
    reset  = 1'b1;
    chk_en = 1'b1;
    base_acks = ack_cnt;
    idle(20);
    chk("ack_after_reset", 16'(ack_cnt), 16'(base_acks));

    idle(5);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/code_display_ctrl.md
CODE_DISPLAY_CTRL -- requirements
Module: code_display_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit stays selected; legal range 2..65535.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum cycles a newly loaded code is shown before another is accepted; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 code  input  4  binary code 0..15 from the encoder.
REQ-006 code_valid  input  1  producer holds high with stable code until code_ack is seen.
REQ-007 clear  input  1  level request to blank the display and return to idle.
REQ-008 code_ack  output  1  one-cycle acknowledge of a captured code.
REQ-009 seg  output  7  segments a..g, index 0 = a, active-high, for the selected digit.
REQ-010 dig_sel  output  2  one-hot digit enable: 2'b01 = units digit, 2'b10 = tens digit.
REQ-011 busy  output  1  high while a code is being loaded or held (LOAD, HOLD).

Function
REQ-012 FSM states: IDLE, LOAD, HOLD, SHOW.
REQ-013 IDLE: code_valid=1 and clear=0 -> capture code into value register, go to LOAD.
REQ-014 LOAD lasts exactly one cycle: code_ack=1, then go to HOLD with hold counter cleared.
REQ-015 HOLD: hold counter increments each cycle; code_valid ignored; after HOLD_CYCLES cycles in HOLD, go to SHOW.
REQ-016 SHOW: code_valid=1 -> capture code, go to LOAD; value shown until replaced.
REQ-017 clear=1 in IDLE, HOLD or SHOW -> IDLE next cycle; clear has priority over code_valid; a LOAD cycle always completes (ack still issued), then clear is honoured from HOLD.
REQ-018 code_ack is registered: high only in the LOAD state, never for two consecutive cycles.
REQ-019 Digit split: tens = 1 if value >= 10 else 0; units = value - 10*tens (0..9).
REQ-020 Segment patterns (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
REQ-021 Tens digit is blanked (seg=0000000) when value < 10; otherwise it shows pattern 1.
REQ-022 In IDLE, seg=0000000 for both digits.
REQ-023 Scan counter runs in every state from 0 to SCAN_DIV-1; on wrap, dig_sel toggles between units and tens.
REQ-024 seg is combinational from the registered value, the registered dig_sel and the state, so seg always matches the current dig_sel.

Reset
REQ-025 While reset=0 at a clk edge: state=IDLE, value=0, hold counter=0, scan counter=0, dig_sel=2'b01, code_ack=0.
REQ-026 Outputs after reset: seg=0000000, dig_sel=2'b01, code_ack=0, busy=0.
REQ-027 Reset asserted mid-LOAD or mid-HOLD aborts the operation; no code_ack follows reset release unless a new capture occurs.

Structure
REQ-028 Shared package code_display_pkg holds the state enumeration, the ten segment-pattern constants and the blank constant.
REQ-029 One combinational sub-module, seg7_digit (digit 0..9 in, 7 segments out), is instantiated once, fed by the mux of the selected digit.

Verification
REQ-030 Reset, then 10 idle cycles -> seg=0000000 always; dig_sel toggles every 4 cycles starting at 2'b01; code_ack=0.
REQ-031 code=4'd7, code_valid held high -> code_ack=1 for exactly one cycle, 2 cycles after valid is first sampled; units digit shows 1110000; tens digit shows 0000000.
REQ-032 code=4'd13 loaded, then code=4'd2 presented during HOLD -> no ack for 16 HOLD cycles; 2 is accepted in SHOW; tens digit changes from 0110000 to 0000000.
REQ-033 code=4'd15 -> tens digit shows 0110000; units digit shows 1011011.
REQ-034 clear=1 and code_valid=1 in the same SHOW cycle -> IDLE, no ack, seg=0000000 next cycle.
REQ-035 reset pulled low during HOLD with code=4'd9 shown -> on release, IDLE and blank; code_ack stays 0.
